// File: rtl/wash_pkg.sv
// Shared wash-programme types: phase encodings and default phase durations.
package wash_pkg;

  typedef enum logic [2:0] {
    PhIdle   = 3'd0,
    PhFill   = 3'd1,
    PhWash   = 3'd2,
    PhDrain  = 3'd3,
    PhRinse  = 3'd4,
    PhSpin   = 3'd5,
    PhRinse2 = 3'd6,
    PhSpin2  = 3'd7
  } phase_e;

  localparam int unsigned DefTickDiv = 1000;
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefFillT   = 20;
  localparam int unsigned DefWashT   = 60;
  localparam int unsigned DefDrainT  = 10;
  localparam int unsigned DefRinseT  = 30;
  localparam int unsigned DefSpinT   = 40;

  // A zero-length phase would never expire, so it runs for one tick instead.
  function automatic int unsigned eff_dur(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Front-panel and timer-done signal bundle between the panel side (master) and the timer (slave).
interface wash_phase_timer_if
  import wash_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             start;
  logic             door;
  logic             abort;
  logic             tf;
  logic             tw;
  logic             td;
  logic             tr;
  logic             ts;
  phase_e           phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, door, abort,
    input  tf, tw, td, tr, ts, phase, busy, done, remaining
  );

  modport slave (
    input  start, door, abort,
    output tf, tw, td, tr, ts, phase, busy, done, remaining
  );

endinterface

// File: rtl/wash_phase_timer_tick_prescaler.sv
// Divides the clock into duration ticks; count freezes on hold and zeroes on clear.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == Last) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = !hold && (cnt_q == Last);

endmodule

// File: rtl/wash_phase_timer.sv
// Wash-programme phase sequencer and duration timer.
// Optional WASH_PHASE_TIMER_EXTRA_RINSE_EN appends a RINSE2/SPIN2 pass after SPIN.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned FILL_T   = DefFillT,
  parameter int unsigned WASH_T   = DefWashT,
  parameter int unsigned DRAIN_T  = DefDrainT,
  parameter int unsigned RINSE_T  = DefRinseT,
  parameter int unsigned SPIN_T   = DefSpinT
) (
  input logic               clk,
  input logic               reset,
  wash_phase_timer_if.slave bus
);

  localparam logic [CNT_W-1:0] FillD  = CNT_W'(eff_dur(FILL_T));
  localparam logic [CNT_W-1:0] WashD  = CNT_W'(eff_dur(WASH_T));
  localparam logic [CNT_W-1:0] DrainD = CNT_W'(eff_dur(DRAIN_T));
  localparam logic [CNT_W-1:0] RinseD = CNT_W'(eff_dur(RINSE_T));
  localparam logic [CNT_W-1:0] SpinD  = CNT_W'(eff_dur(SPIN_T));

  phase_e           phase_q;
  logic [CNT_W-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             tf_q, tw_q, td_q, tr_q, ts_q;
  logic             tick;

  // Prescaler idles at zero so every programme starts on a fresh tick period.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(phase_q == PhIdle),
    .hold (bus.door),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PhIdle;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tf_q    <= 1'b0;
      tw_q    <= 1'b0;
      td_q    <= 1'b0;
      tr_q    <= 1'b0;
      ts_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tf_q   <= 1'b0;
      tw_q   <= 1'b0;
      td_q   <= 1'b0;
      tr_q   <= 1'b0;
      ts_q   <= 1'b0;
      if (bus.abort) begin
        phase_q <= PhIdle;
        rem_q   <= '0;
        busy_q  <= 1'b0;
      end else if (phase_q == PhIdle) begin
        if (bus.start && !bus.door) begin
          phase_q <= PhFill;
          rem_q   <= FillD;
          busy_q  <= 1'b1;
        end
      end else if (tick) begin
        if (rem_q == CNT_W'(1)) begin
          case (phase_q)
            PhFill: begin
              tf_q    <= 1'b1;
              phase_q <= PhWash;
              rem_q   <= WashD;
            end
            PhWash: begin
              tw_q    <= 1'b1;
              phase_q <= PhDrain;
              rem_q   <= DrainD;
            end
            PhDrain: begin
              td_q    <= 1'b1;
              phase_q <= PhRinse;
              rem_q   <= RinseD;
            end
            PhRinse: begin
              tr_q    <= 1'b1;
              phase_q <= PhSpin;
              rem_q   <= SpinD;
            end
            PhSpin: begin
              ts_q <= 1'b1;
`ifdef WASH_PHASE_TIMER_EXTRA_RINSE_EN
              phase_q <= PhRinse2;
              rem_q   <= RinseD;
`else
              done_q  <= 1'b1;
              phase_q <= PhIdle;
              rem_q   <= '0;
              busy_q  <= 1'b0;
`endif
            end
            PhRinse2: begin
              tr_q    <= 1'b1;
              phase_q <= PhSpin2;
              rem_q   <= SpinD;
            end
            PhSpin2: begin
              ts_q    <= 1'b1;
              done_q  <= 1'b1;
              phase_q <= PhIdle;
              rem_q   <= '0;
              busy_q  <= 1'b0;
            end
            default: begin
              phase_q <= PhIdle;
              rem_q   <= '0;
              busy_q  <= 1'b0;
            end
          endcase
        end else begin
          rem_q <= rem_q - CNT_W'(1);
        end
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tf        = tf_q;
  assign bus.tw        = tw_q;
  assign bus.td        = td_q;
  assign bus.tr        = tr_q;
  assign bus.ts        = ts_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench: expected timer-done pulses are queued per programme, a monitor pops on pulses.
module tb_wash_phase_timer;
  import wash_pkg::*;

  typedef struct {
    int         rel;
    logic [5:0] ev;
  } exp_t;

  localparam logic [5:0] EvTf   = 6'b000001;
  localparam logic [5:0] EvTw   = 6'b000010;
  localparam logic [5:0] EvTd   = 6'b000100;
  localparam logic [5:0] EvTr   = 6'b001000;
  localparam logic [5:0] EvTs   = 6'b010000;
  localparam logic [5:0] EvDone = 6'b100000;

`ifdef WASH_PHASE_TIMER_EXTRA_RINSE_EN
  localparam int End1 = 14;
  localparam int End4 = 56;
`else
  localparam int End1 = 10;
  localparam int End4 = 40;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wash_phase_timer_if #(.CNT_W(16)) b1 ();
  wash_phase_timer_if #(.CNT_W(16)) b4 ();

  wash_phase_timer #(
    .TICK_DIV(1), .CNT_W(16), .FILL_T(2), .WASH_T(3), .DRAIN_T(1), .RINSE_T(2), .SPIN_T(2)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (b1)
  );

  wash_phase_timer #(
    .TICK_DIV(4), .CNT_W(16), .FILL_T(2), .WASH_T(3), .DRAIN_T(1), .RINSE_T(2), .SPIN_T(2)
  ) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (b4)
  );

  int   cyc = 0;
  int   base1 = 0;
  int   base4 = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q4[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp1(input int rel, input logic [5:0] ev);
    q1.push_back('{rel: rel, ev: ev});
  endtask

  task automatic exp4(input int rel, input logic [5:0] ev);
    q4.push_back('{rel: rel, ev: ev});
  endtask

  task automatic push_nominal1();
    exp1(2, EvTf);
    exp1(5, EvTw);
    exp1(6, EvTd);
    exp1(8, EvTr);
`ifdef WASH_PHASE_TIMER_EXTRA_RINSE_EN
    exp1(10, EvTs);
    exp1(12, EvTr);
    exp1(14, EvTs | EvDone);
`else
    exp1(10, EvTs | EvDone);
`endif
  endtask

  // Cycle 0 is the first cycle with phase=FILL.
  task automatic go1();
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    base1 = cyc;
  endtask

  task automatic go4();
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    base4 = cyc;
  endtask

  task automatic wait1(input int k);
    while (cyc - base1 < k) @(negedge clk);
  endtask

  task automatic wait4(input int k);
    while (cyc - base4 < k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [5:0] ev;
    exp_t       e;
    ev = {b1.done, b1.ts, b1.tr, b1.td, b1.tw, b1.tf};
    if (ev != 6'b0) begin
      if (q1.size() == 0) begin
        chk("unexpected pulse dut1", int'(ev), 0);
      end else begin
        e = q1.pop_front();
        chk("pulse set dut1", int'(ev), int'(e.ev));
        chk("pulse cycle dut1", cyc - base1, e.rel);
      end
    end
    ev = {b4.done, b4.ts, b4.tr, b4.td, b4.tw, b4.tf};
    if (ev != 6'b0) begin
      if (q4.size() == 0) begin
        chk("unexpected pulse dut4", int'(ev), 0);
      end else begin
        e = q4.pop_front();
        chk("pulse set dut4", int'(ev), int'(e.ev));
        chk("pulse cycle dut4", cyc - base4, e.rel);
      end
    end
  end

  initial begin
    b1.start = 1'b0;
    b1.door  = 1'b0;
    b1.abort = 1'b0;
    b4.start = 1'b0;
    b4.door  = 1'b0;
    b4.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset phase", int'(b1.phase), 0);
    chk("reset busy", int'(b1.busy), 0);
    chk("reset remaining", int'(b1.remaining), 0);
    chk("reset done", int'(b1.done), 0);
    reset = 1'b0;

    // Nominal programme
    push_nominal1();
    go1();
    chk("nominal entry phase", int'(b1.phase), 1);
    chk("nominal entry busy", int'(b1.busy), 1);
    chk("nominal entry remaining", int'(b1.remaining), 2);
    wait1(End1);
    chk("nominal end phase", int'(b1.phase), 0);
    chk("nominal end busy", int'(b1.busy), 0);
    wait1(End1 + 1);
    chk("nominal idle remaining", int'(b1.remaining), 0);
    chk("nominal idle busy", int'(b1.busy), 0);

    // Start ignored with door open
    b1.door  = 1'b1;
    b1.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("door start phase", int'(b1.phase), 0);
    chk("door start busy", int'(b1.busy), 0);
    b1.start = 1'b0;
    b1.door  = 1'b0;

    // Door open for 5 cycles during WASH delays everything by 5
    exp1(2, EvTf);
    exp1(10, EvTw);
    exp1(11, EvTd);
    exp1(13, EvTr);
`ifdef WASH_PHASE_TIMER_EXTRA_RINSE_EN
    exp1(15, EvTs);
    exp1(17, EvTr);
    exp1(19, EvTs | EvDone);
`else
    exp1(15, EvTs | EvDone);
`endif
    go1();
    wait1(3);
    chk("door wash remaining before", int'(b1.remaining), 2);
    b1.door = 1'b1;
    wait1(4);
    chk("door frozen remaining c4", int'(b1.remaining), 2);
    wait1(8);
    chk("door frozen remaining c8", int'(b1.remaining), 2);
    chk("door frozen phase", int'(b1.phase), 2);
    b1.door = 1'b0;
    wait1(End1 + 7);

    // Abort on the DRAIN expiry cycle
    exp1(2, EvTf);
    exp1(5, EvTw);
    go1();
    wait1(5);
    chk("abort pre phase", int'(b1.phase), 3);
    b1.abort = 1'b1;
    wait1(6);
    b1.abort = 1'b0;
    chk("abort phase", int'(b1.phase), 0);
    chk("abort busy", int'(b1.busy), 0);
    chk("abort remaining", int'(b1.remaining), 0);
    wait1(18);

    // Reset in RINSE, then a fresh nominal run
    exp1(2, EvTf);
    exp1(5, EvTw);
    exp1(6, EvTd);
    go1();
    wait1(6);
    chk("midreset pre phase", int'(b1.phase), 4);
    reset = 1'b1;
    wait1(7);
    reset = 1'b0;
    chk("midreset phase", int'(b1.phase), 0);
    chk("midreset busy", int'(b1.busy), 0);
    chk("midreset remaining", int'(b1.remaining), 0);
    push_nominal1();
    go1();
    chk("rerun entry remaining", int'(b1.remaining), 2);
    wait1(End1 + 2);
    chk("rerun end busy", int'(b1.busy), 0);

    // Prescaler with TICK_DIV=4; a start during FILL does nothing
    exp4(8, EvTf);
    exp4(20, EvTw);
    exp4(24, EvTd);
    exp4(32, EvTr);
`ifdef WASH_PHASE_TIMER_EXTRA_RINSE_EN
    exp4(40, EvTs);
    exp4(48, EvTr);
    exp4(56, EvTs | EvDone);
`else
    exp4(40, EvTs | EvDone);
`endif
    go4();
    chk("presc entry remaining", int'(b4.remaining), 2);
    wait4(3);
    chk("presc c3 remaining", int'(b4.remaining), 2);
    b4.start = 1'b1;
    wait4(4);
    b4.start = 1'b0;
    chk("presc c4 phase", int'(b4.phase), 1);
    chk("presc c4 remaining", int'(b4.remaining), 1);
    wait4(End4 + 2);
    chk("presc end busy", int'(b4.busy), 0);

    chk("dut1 pending expectations", q1.size(), 0);
    chk("dut4 pending expectations", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
